// File: rtl/stream_mux_rr.sv
// N-channel packet stream mux with round-robin or fixed-priority arbitration and packet locking.
// Latency: 1 cycle from input accept to registered output.
// Backpressure: out_valid & !out_ready freezes out_* and drops every in_ready to 0.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0] out_sel,
  input  logic                     out_ready
);

  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;

  logic             slot_free;
  logic             any_valid;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] acc_ch;
  logic             accept;
  logic [DATA_W-1:0] acc_data;
  logic             acc_last;
  logic [SEL_W-1:0] next_ptr;

  // The output register can take a new beat when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  // Winner search: round-robin starts at rr_ptr and wraps, fixed priority starts at 0.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [SEL_W-1:0] idx;
      if (MODE == 0) begin
        idx = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
      end else begin
        idx = SEL_W'(i);
      end
      if (!any_valid && in_valid[idx]) begin
        win       = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Accept steering: new winner when idle, only the locked channel otherwise.
  always_comb begin
    in_ready = '0;
    if (rst_n) begin
      if (state == IDLE) begin
        if (slot_free && any_valid) begin
          in_ready[win] = 1'b1;
        end
      end else begin
        in_ready[grant] = slot_free;
      end
    end
  end

  assign acc_ch   = (state == IDLE) ? win : grant;
  assign accept   = |(in_ready & in_valid);
  assign acc_data = in_data[int'(acc_ch)*DATA_W +: DATA_W];
  assign acc_last = in_last[acc_ch];

  // The channel just served drops to lowest priority for the next packet.
  assign next_ptr = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

  // Packet FSM, round-robin pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= acc_last;
        out_data  <= acc_data;
        out_sel   <= acc_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= next_ptr;
            if (!acc_last) begin
              state <= LOCKED;
              grant <= win;
            end
          end
        end
        LOCKED: begin
          if (accept && acc_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
